ex_top: RTL and testbench

EX_TOP -- requirements
Module: EX_top

---
 rtl/rv32i_definitions.sv | 43 ++++
 rtl/ex_alu.sv | 32 +++
 rtl/ex_top.sv | 137 +++++++++++++
 tb/tb_ex_top.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_definitions.sv
// rtl/rv32i_definitions.sv - shared ALU, branch and memory-width codes for the RV32I pipeline
package rv32i_definitions;

  // ALU operation codes carried on ID_ALU_op; any other code makes the ALU output 0.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SRL   = 4'd3,
    ALU_SRA   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_XOR   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // Branch condition codes carried on ID_Branch_op; 6 behaves like NONE.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_NONE = 3'd7
  } branch_op_e;

  // Load/store width codes; EX only forwards them to the MEM stage.
  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd4,
    MEM_HU = 3'd5
  } mem_op_e;

  function automatic logic is_branch(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational RV32I ALU
//   op     : ALU operation code (alu_op_e)
//   a, b   : operands
//   result : operation result, 0 for undefined codes
module ex_alu
  import rv32i_definitions::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << b[4:0];
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $signed(a) >>> b[4:0];
      ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'b0, a < b};
      ALU_XOR:   result = a ^ b;
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_top.sv
// rtl/ex_top.sv - RV32I execute stage: forwarding, load-use hazard, branch resolution, EX/MEM register
//   Clk, Reset          : clock, asynchronous active-high reset
//   ID_*                : decoded instruction from the ID stage
//   MEM_*               : MEM/WB forwarding source
//   EX_* (registered)   : result, store data and control to the MEM stage
//   EX_Branch_taken/target, EX_Stall : combinational redirect and hazard outputs
module ex_top
  import rv32i_definitions::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] ID_PC,
  input  logic [31:0] ID_Imm,
  input  logic [31:0] ID_Rs1_data,
  input  logic [31:0] ID_Rs2_data,
  input  logic [4:0]  ID_Rs1_addr,
  input  logic [4:0]  ID_Rs2_addr,
  input  logic [4:0]  ID_Rd_addr,
  input  logic [3:0]  ID_ALU_op,
  input  logic        ID_ALU_srcA,
  input  logic        ID_ALU_srcB,
  input  logic [2:0]  ID_Branch_op,
  input  logic        ID_Jump,
  input  logic        ID_Jalr,
  input  logic        ID_Mem_wr_en,
  input  logic        ID_Mem_rd_en,
  input  logic        ID_MemToReg,
  input  logic        ID_RegFile_wr_en,
  input  logic [2:0]  ID_Mem_op,
  input  logic        ID_Valid,
  input  logic [31:0] MEM_ALU_result,
  input  logic [4:0]  MEM_Rd_addr,
  input  logic        MEM_RegFile_wr_en,
  output logic [31:0] EX_ALU_result,
  output logic [31:0] EX_Rs2_data,
  output logic [4:0]  EX_Rd_addr,
  output logic [2:0]  EX_Mem_op,
  output logic        EX_Mem_wr_en,
  output logic        EX_Mem_rd_en,
  output logic        EX_MemToReg,
  output logic        EX_RegFile_wr_en,
  output logic        EX_Branch_taken,
  output logic [31:0] EX_Branch_target,
  output logic        EX_Stall
);

  logic [31:0] rs1_fwd, rs2_fwd;
  logic [31:0] alu_a, alu_b, alu_out, result;
  logic        use_rs1, use_rs2, cond;

  // A load in EX has no data yet, so it is never an EX forward source.
  logic ex_fwd_ok, mem_fwd_ok;
  assign ex_fwd_ok  = EX_RegFile_wr_en && !EX_Mem_rd_en && (EX_Rd_addr != 5'd0);
  assign mem_fwd_ok = MEM_RegFile_wr_en && (MEM_Rd_addr != 5'd0);

  always_comb begin
    rs1_fwd = ID_Rs1_data;
    rs2_fwd = ID_Rs2_data;
    if (FWD_EN) begin
      if (ex_fwd_ok && EX_Rd_addr == ID_Rs1_addr)        rs1_fwd = EX_ALU_result;
      else if (mem_fwd_ok && MEM_Rd_addr == ID_Rs1_addr) rs1_fwd = MEM_ALU_result;
      if (ex_fwd_ok && EX_Rd_addr == ID_Rs2_addr)        rs2_fwd = EX_ALU_result;
      else if (mem_fwd_ok && MEM_Rd_addr == ID_Rs2_addr) rs2_fwd = MEM_ALU_result;
    end
  end

  // A source counts as used when it feeds the ALU, a compare, the JALR base or store data.
  assign use_rs1 = !ID_ALU_srcA || ID_Jalr || is_branch(ID_Branch_op);
  assign use_rs2 = !ID_ALU_srcB || is_branch(ID_Branch_op) || ID_Mem_wr_en;

  assign EX_Stall = ID_Valid && EX_Mem_rd_en && (EX_Rd_addr != 5'd0) &&
                    ((use_rs1 && EX_Rd_addr == ID_Rs1_addr) ||
                     (use_rs2 && EX_Rd_addr == ID_Rs2_addr));

  assign alu_a = ID_ALU_srcA ? ID_PC  : rs1_fwd;
  assign alu_b = ID_ALU_srcB ? ID_Imm : rs2_fwd;

  ex_alu u_alu (
    .op     (ID_ALU_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_out)
  );

  assign result = (ID_Jump || ID_Jalr) ? ID_PC + 32'd4 : alu_out;

  always_comb begin
    cond = 1'b0;
    case (branch_op_e'(ID_Branch_op))
      BR_BEQ:  cond = rs1_fwd == rs2_fwd;
      BR_BNE:  cond = rs1_fwd != rs2_fwd;
      BR_BLT:  cond = $signed(rs1_fwd) <  $signed(rs2_fwd);
      BR_BGE:  cond = $signed(rs1_fwd) >= $signed(rs2_fwd);
      BR_BLTU: cond = rs1_fwd <  rs2_fwd;
      BR_BGEU: cond = rs1_fwd >= rs2_fwd;
      default: cond = 1'b0;
    endcase
  end

  assign EX_Branch_taken  = ID_Valid && !EX_Stall && (ID_Jump || ID_Jalr || cond);
  assign EX_Branch_target = ID_Jalr ? ((rs1_fwd + ID_Imm) & ~32'd1) : ID_PC + ID_Imm;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      EX_ALU_result    <= '0;
      EX_Rs2_data      <= '0;
      EX_Rd_addr       <= '0;
      EX_Mem_op        <= '0;
      EX_Mem_wr_en     <= 1'b0;
      EX_Mem_rd_en     <= 1'b0;
      EX_MemToReg      <= 1'b0;
      EX_RegFile_wr_en <= 1'b0;
    end else if (ID_Valid && !EX_Stall) begin
      EX_ALU_result    <= result;
      EX_Rs2_data      <= rs2_fwd;
      EX_Rd_addr       <= ID_Rd_addr;
      EX_Mem_op        <= ID_Mem_op;
      EX_Mem_wr_en     <= ID_Mem_wr_en;
      EX_Mem_rd_en     <= ID_Mem_rd_en;
      EX_MemToReg      <= ID_MemToReg;
      EX_RegFile_wr_en <= ID_RegFile_wr_en;
    end else begin
      // Bubble: the stalled instruction is re-presented by ID next cycle.
      EX_ALU_result    <= '0;
      EX_Rs2_data      <= '0;
      EX_Rd_addr       <= '0;
      EX_Mem_op        <= '0;
      EX_Mem_wr_en     <= 1'b0;
      EX_Mem_rd_en     <= 1'b0;
      EX_MemToReg      <= 1'b0;
      EX_RegFile_wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_top.sv
// tb/tb_ex_top.sv - directed self-checking bench for ex_top
module tb_ex_top;
  import rv32i_definitions::*;

  logic        Clk, Reset;
  logic [31:0] ID_PC, ID_Imm, ID_Rs1_data, ID_Rs2_data;
  logic [4:0]  ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr;
  logic [3:0]  ID_ALU_op;
  logic        ID_ALU_srcA, ID_ALU_srcB;
  logic [2:0]  ID_Branch_op;
  logic        ID_Jump, ID_Jalr;
  logic        ID_Mem_wr_en, ID_Mem_rd_en, ID_MemToReg, ID_RegFile_wr_en;
  logic [2:0]  ID_Mem_op;
  logic        ID_Valid;
  logic [31:0] MEM_ALU_result;
  logic [4:0]  MEM_Rd_addr;
  logic        MEM_RegFile_wr_en;
  logic [31:0] EX_ALU_result, EX_Rs2_data;
  logic [4:0]  EX_Rd_addr;
  logic [2:0]  EX_Mem_op;
  logic        EX_Mem_wr_en, EX_Mem_rd_en, EX_MemToReg, EX_RegFile_wr_en;
  logic        EX_Branch_taken;
  logic [31:0] EX_Branch_target;
  logic        EX_Stall;

  int total = 0;
  int bad   = 0;

  ex_top #(.FWD_EN(1'b1)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_PC(ID_PC), .ID_Imm(ID_Imm), .ID_Rs1_data(ID_Rs1_data), .ID_Rs2_data(ID_Rs2_data),
    .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr), .ID_Rd_addr(ID_Rd_addr),
    .ID_ALU_op(ID_ALU_op), .ID_ALU_srcA(ID_ALU_srcA), .ID_ALU_srcB(ID_ALU_srcB),
    .ID_Branch_op(ID_Branch_op), .ID_Jump(ID_Jump), .ID_Jalr(ID_Jalr),
    .ID_Mem_wr_en(ID_Mem_wr_en), .ID_Mem_rd_en(ID_Mem_rd_en), .ID_MemToReg(ID_MemToReg),
    .ID_RegFile_wr_en(ID_RegFile_wr_en), .ID_Mem_op(ID_Mem_op), .ID_Valid(ID_Valid),
    .MEM_ALU_result(MEM_ALU_result), .MEM_Rd_addr(MEM_Rd_addr), .MEM_RegFile_wr_en(MEM_RegFile_wr_en),
    .EX_ALU_result(EX_ALU_result), .EX_Rs2_data(EX_Rs2_data), .EX_Rd_addr(EX_Rd_addr),
    .EX_Mem_op(EX_Mem_op), .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_rd_en(EX_Mem_rd_en),
    .EX_MemToReg(EX_MemToReg), .EX_RegFile_wr_en(EX_RegFile_wr_en),
    .EX_Branch_taken(EX_Branch_taken), .EX_Branch_target(EX_Branch_target), .EX_Stall(EX_Stall)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_id();
    ID_PC = '0; ID_Imm = '0; ID_Rs1_data = '0; ID_Rs2_data = '0;
    ID_Rs1_addr = '0; ID_Rs2_addr = '0; ID_Rd_addr = '0;
    ID_ALU_op = ALU_ADD; ID_ALU_srcA = 1'b0; ID_ALU_srcB = 1'b0;
    ID_Branch_op = BR_NONE; ID_Jump = 1'b0; ID_Jalr = 1'b0;
    ID_Mem_wr_en = 1'b0; ID_Mem_rd_en = 1'b0; ID_MemToReg = 1'b0; ID_RegFile_wr_en = 1'b0;
    ID_Mem_op = '0; ID_Valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    clear_id();
    MEM_ALU_result = '0; MEM_Rd_addr = '0; MEM_RegFile_wr_en = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_result", EX_ALU_result, 32'h0);
    chk("rst_rd", {27'b0, EX_Rd_addr}, 32'h0);
    chk("rst_en", {28'b0, EX_Mem_wr_en, EX_Mem_rd_en, EX_MemToReg, EX_RegFile_wr_en}, 32'h0);
    chk("rst_stall", {31'b0, EX_Stall}, 32'h0);
    chk("rst_taken", {31'b0, EX_Branch_taken}, 32'h0);
    Reset = 1'b0;

    // ADD x1 = x0 + 5
    ID_Valid = 1'b1; ID_ALU_srcB = 1'b1; ID_Imm = 32'd5; ID_Rd_addr = 5'd1; ID_RegFile_wr_en = 1'b1;
    tick();
    chk("add_x1", EX_ALU_result, 32'd5);
    chk("add_x1_rd", {27'b0, EX_Rd_addr}, 32'd1);

    // ADD x3 = x1(stale 0) + 7 -> EX forward
    ID_Rs1_addr = 5'd1; ID_Imm = 32'd7; ID_Rd_addr = 5'd3;
    tick();
    chk("fwd_ex", EX_ALU_result, 32'd12);

    // EX (x3=12) beats MEM (x3=200)
    MEM_Rd_addr = 5'd3; MEM_ALU_result = 32'd200; MEM_RegFile_wr_en = 1'b1;
    ID_Rs1_addr = 5'd3; ID_Imm = 32'd1; ID_Rd_addr = 5'd4;
    tick();
    chk("fwd_ex_priority", EX_ALU_result, 32'd13);

    // MEM forward x2=100
    MEM_Rd_addr = 5'd2; MEM_ALU_result = 32'd100;
    ID_Rs1_addr = 5'd2;
    tick();
    chk("fwd_mem", EX_ALU_result, 32'd101);

    // write to x0, then x0 must never be forwarded from EX or MEM
    ID_Rs1_addr = 5'd0; ID_Imm = 32'd9; ID_Rd_addr = 5'd0;
    tick();
    MEM_Rd_addr = 5'd0; MEM_ALU_result = 32'd55;
    ID_Imm = 32'd1; ID_Rd_addr = 5'd4;
    tick();
    chk("no_fwd_x0", EX_ALU_result, 32'd1);
    MEM_RegFile_wr_en = 1'b0;

    // LW x5 then ADD x6 = x5 + x0 -> stall, bubble, then capture with MEM forward
    clear_id();
    ID_Valid = 1'b1; ID_ALU_srcB = 1'b1; ID_Imm = 32'h40; ID_Mem_rd_en = 1'b1; ID_MemToReg = 1'b1;
    ID_RegFile_wr_en = 1'b1; ID_Rd_addr = 5'd5; ID_Mem_op = MEM_W;
    tick();
    chk("load_rd_en", {31'b0, EX_Mem_rd_en}, 32'h1);
    chk("load_addr", EX_ALU_result, 32'h40);
    clear_id();
    ID_Valid = 1'b1; ID_Rs1_addr = 5'd5; ID_Rd_addr = 5'd6; ID_RegFile_wr_en = 1'b1;
    #1;
    chk("load_use_stall", {31'b0, EX_Stall}, 32'h1);
    tick();
    chk("bubble_en", {28'b0, EX_Mem_wr_en, EX_Mem_rd_en, EX_MemToReg, EX_RegFile_wr_en}, 32'h0);
    chk("bubble_rd", {27'b0, EX_Rd_addr}, 32'h0);
    chk("bubble_result", EX_ALU_result, 32'h0);
    chk("stall_released", {31'b0, EX_Stall}, 32'h0);
    MEM_Rd_addr = 5'd5; MEM_ALU_result = 32'h77; MEM_RegFile_wr_en = 1'b1;
    tick();
    chk("after_stall_result", EX_ALU_result, 32'h77);
    chk("after_stall_rd", {27'b0, EX_Rd_addr}, 32'd6);
    MEM_RegFile_wr_en = 1'b0;

    // stall suppresses a branch that would otherwise be taken
    clear_id();
    ID_Valid = 1'b1; ID_ALU_srcB = 1'b1; ID_Mem_rd_en = 1'b1; ID_RegFile_wr_en = 1'b1; ID_Rd_addr = 5'd5;
    tick();
    clear_id();
    ID_Valid = 1'b1; ID_Branch_op = BR_BNE; ID_Rs1_addr = 5'd5; ID_Rs1_data = 32'd1;
    ID_PC = 32'h100; ID_Imm = 32'h20;
    #1;
    chk("stall_vs_branch_stall", {31'b0, EX_Stall}, 32'h1);
    chk("stall_vs_branch_taken", {31'b0, EX_Branch_taken}, 32'h0);
    tick();

    // branches on non-forwarded operands
    clear_id();
    ID_Valid = 1'b1; ID_Rs1_addr = 5'd7; ID_Rs2_addr = 5'd8; ID_Rs1_data = 32'd1; ID_Rs2_data = 32'd2;
    ID_PC = 32'h100; ID_Imm = 32'h20; ID_Branch_op = BR_BNE;
    #1;
    chk("bne_taken", {31'b0, EX_Branch_taken}, 32'h1);
    chk("bne_target", EX_Branch_target, 32'h120);
    ID_Branch_op = BR_BEQ; #1;
    chk("beq_not_taken", {31'b0, EX_Branch_taken}, 32'h0);
    ID_Rs1_data = 32'hFFFF_FFFF; ID_Rs2_data = 32'd1; ID_Branch_op = BR_BLT; #1;
    chk("blt_signed", {31'b0, EX_Branch_taken}, 32'h1);
    ID_Branch_op = BR_BLTU; #1;
    chk("bltu_unsigned", {31'b0, EX_Branch_taken}, 32'h0);

    // JALR
    clear_id();
    ID_Valid = 1'b1; ID_Jalr = 1'b1; ID_Rs1_addr = 5'd9; ID_Rs1_data = 32'h1001; ID_Imm = 32'd4;
    ID_PC = 32'h40; ID_ALU_srcB = 1'b1; ID_Rd_addr = 5'd1; ID_RegFile_wr_en = 1'b1;
    #1;
    chk("jalr_taken", {31'b0, EX_Branch_taken}, 32'h1);
    chk("jalr_target", EX_Branch_target, 32'h1004);
    tick();
    chk("jalr_link", EX_ALU_result, 32'h44);

    // ALU corner cases
    clear_id();
    ID_Valid = 1'b1; ID_Rs1_addr = 5'd10; ID_ALU_srcB = 1'b1; ID_Rd_addr = 5'd11; ID_RegFile_wr_en = 1'b1;
    ID_ALU_op = ALU_SRA; ID_Rs1_data = 32'h8000_0000; ID_Imm = 32'd4;
    tick();
    chk("sra", EX_ALU_result, 32'hF800_0000);
    ID_ALU_op = ALU_SLTU; ID_Rs1_data = 32'hFFFF_FFFF; ID_Imm = 32'd1;
    tick();
    chk("sltu", EX_ALU_result, 32'h0);
    ID_ALU_op = ALU_SLT;
    tick();
    chk("slt", EX_ALU_result, 32'h1);
    ID_ALU_op = ALU_SUB; ID_Rs1_data = 32'd5; ID_Imm = 32'd7;
    tick();
    chk("sub_wrap", EX_ALU_result, 32'hFFFF_FFFE);
    ID_ALU_op = 4'd15;
    tick();
    chk("undefined_op", EX_ALU_result, 32'h0);

    // store data carries forwarded rs2
    ID_ALU_op = ALU_ADD; ID_Rs1_data = 32'h10; ID_Imm = 32'h20; ID_Rd_addr = 5'd12;
    tick();
    clear_id();
    ID_Valid = 1'b1; ID_Rs2_addr = 5'd12; ID_ALU_srcB = 1'b1; ID_Imm = 32'd8; ID_Mem_wr_en = 1'b1;
    ID_Mem_op = MEM_W;
    tick();
    chk("store_rs2_fwd", EX_Rs2_data, 32'h30);
    chk("store_wr_en", {31'b0, EX_Mem_wr_en}, 32'h1);
    chk("store_addr", EX_ALU_result, 32'd8);

    // invalid ID slot becomes a bubble
    ID_Valid = 1'b0;
    tick();
    chk("invalid_bubble", {28'b0, EX_Mem_wr_en, EX_Mem_rd_en, EX_MemToReg, EX_RegFile_wr_en}, 32'h0);

    // asynchronous reset between edges, then first edge captures normally
    clear_id();
    ID_Valid = 1'b1; ID_ALU_srcB = 1'b1; ID_Imm = 32'h55; ID_Rd_addr = 5'd13; ID_RegFile_wr_en = 1'b1;
    tick();
    chk("pre_reset_result", EX_ALU_result, 32'h55);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_result", EX_ALU_result, 32'h0);
    chk("async_rst_rd", {27'b0, EX_Rd_addr}, 32'h0);
    chk("async_rst_wr", {31'b0, EX_RegFile_wr_en}, 32'h0);
    #1 Reset = 1'b0;
    tick();
    chk("post_reset_capture", EX_ALU_result, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
